fetch_prefetch_unit: RTL and testbench
======================================

# fetch_prefetch_unit

Parametrised instruction-fetch front end. It generates sequential fetch addresses and issues word reads to instruction memory over a request/valid handshake. Returned instructions are buffered in a DEPTH-entry prefetch FIFO and delivered to decode over a valid/ready handshake. Branch redirect flushes the buffer and discards any in-flight response. Fetch issue is suppressed while a data-memory load is pending.

## Interface
Parameters:
- XLEN, 32: address/instruction width.
- DEPTH, 4: prefetch FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- redirect  in  1  taken branch/jump this cycle.
- redirect_pc  in  XLEN  target address when redirect=1.
- load_stall  in  1  load outstanding and data memory not yet valid; blocks new issue.
- imem_req  out  1  read request to instruction memory.
- imem_we_re  out  1  constant 0 (read).
- imem_mask  out  4  constant 4'b1111.
- imem_addr  out  XLEN  fetch address; stable while imem_req=1 and no response.
- imem_valid  in  1  response strobe; one per accepted request, ≥1 cycle after issue.
- imem_rdata  in  XLEN  instruction word, sampled when imem_valid=1.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  decode accepts head entry.
- out_instr  out  XLEN  head instruction.
- out_pc  out  XLEN  address of head instruction.
- fetch_misalign  out  1  sticky misaligned-redirect flag; see Configuration.

## Operation
- Registers:
  - fetch_pc: next address to issue.
  - FIFO of {pc, instr} with head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - count: 0..DEPTH, log2(DEPTH)+1 bits.
  - FSM state.
- At most one outstanding request.
- FSM:
  - IDLE: imem_req = !rst && !load_stall && count<DEPTH && !redirect. On issue → WAIT.
  - WAIT: imem_req held at 1 and imem_addr = fetch_pc. It is not withdrawn by load_stall.
    - On imem_valid: push {fetch_pc, imem_rdata}, fetch_pc += 4 (modulo 2^XLEN), → IDLE.
  - DROP: imem_req=0. Waits for the orphaned response.
    - On imem_valid: discard the data, → IDLE.
- Redirect has priority over every other event in the same cycle:
  - FIFO flushed: count=0, head=tail=0.
  - fetch_pc ← redirect_pc.
  - A pop in the same cycle is ignored.
  - State transitions:
    - IDLE → IDLE.
    - WAIT without imem_valid → DROP.
    - WAIT with imem_valid → IDLE, response discarded.
    - DROP with imem_valid → IDLE.
    - DROP without imem_valid → DROP, with the new fetch_pc.
- Pop occurs when out_valid && out_ready. Push and pop in the same cycle leave count unchanged. This is legal when count==DEPTH only if no push is possible; the WAIT issue rule guarantees a free slot for every response.
- Issue is allowed only when count<DEPTH. A pop in the same cycle does not enable issue.

## Timing
- Reset values:
  - imem_req=0, out_valid=0, out_instr=0, out_pc=0, fetch_misalign=0.
  - State IDLE, count=0, fetch_pc=RESET_PC.
- First request occurs in the first cycle after rst deasserts, with imem_addr=RESET_PC.
- Response to output: data registered on the imem_valid edge; out_valid=1 the following cycle.
- Redirect to request: the new request is issued the cycle after redirect if the state was IDLE. Otherwise it is issued the cycle after the orphaned response.
- Steady-state throughput with 1-cycle memory: one instruction every 2 cycles.
- rst asserted mid-WAIT returns the block to reset state immediately. Any later imem_valid is ignored until a request is issued.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0]≠0 sets fetch_misalign=1 and loads fetch_pc normally.
  - While fetch_misalign=1, no further issue occurs.
  - Only rst clears it.
- Not defined:
  - fetch_pc ← {redirect_pc[XLEN-1:2], 2'b00}.
  - fetch_misalign is tied to 0.

## Test plan
- Reset then 1-cycle memory, out_ready=1 → requests to 0x0, 0x4, 0x8. out_pc follows 0x0, 0x4, 0x8 and out_instr matches memory.
- DEPTH=4, out_ready=0 → exactly 4 responses buffered, count=4, imem_req stays 0. Raising out_ready for one cycle → one pop, then one new request to 0x10.
- Redirect to 0x100 while in WAIT with 3-cycle memory latency → the orphaned response is discarded, the FIFO is empty, and the next imem_addr is 0x100.
- Redirect and imem_valid in the same cycle → response dropped, out_valid=0 next cycle, next request to the redirect target.
- load_stall=1 in IDLE → imem_req=0 for the whole stall. load_stall asserted during WAIT → request held until imem_valid.
- Redirect to 0x102:
  - With FETCH_ALIGN_CHECK_EN → fetch_misalign=1 and no further requests.
  - Without it → next imem_addr=0x100.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - instruction fetch front end with prefetch FIFO (optional FETCH_ALIGN_CHECK_EN)

module fetch_prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            load_stall,
    output logic            imem_req,
    output logic            imem_we_re,
    output logic [3:0]      imem_mask,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            fetch_misalign
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE    = AW'(1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [AW-1:0]   head, tail;
    logic [AW:0]     count;
    logic            misalign_q;
    logic            issue_ok, push, pop;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_target = redirect_pc;

    always_ff @(posedge clk) begin
        if (rst)
            misalign_q <= 1'b0;
        else if (redirect && redirect_pc[1:0] != 2'b00)
            misalign_q <= 1'b1;
    end
`else
    assign redirect_target = redirect_pc & ~XLEN'(3);
    assign misalign_q      = 1'b0;
`endif

    // A pop in the same cycle never frees a slot for issue: the slot check uses count only.
    assign issue_ok = !rst && !load_stall && (count < FULL_COUNT) && !redirect && !misalign_q;
    assign pop      = out_valid && out_ready && !redirect;

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        push      = 1'b0;
        case (state)
            S_IDLE: begin
                imem_req = issue_ok;
                if (issue_ok)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                imem_req = !rst;
                if (imem_valid) begin
                    push      = !redirect;
                    state_nxt = S_IDLE;
                end else if (redirect) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_valid)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                fetch_pc <= redirect_target;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    tail     <= tail + PTR_ONE;
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (pop)
                    head <= head + PTR_ONE;
                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[tail]    <= fetch_pc;
            instr_mem[tail] <= imem_rdata;
        end
    end

    assign imem_we_re     = 1'b0;
    assign imem_mask      = 4'b1111;
    assign imem_addr      = fetch_pc;
    assign out_valid      = (count != '0);
    assign out_instr      = out_valid ? instr_mem[head] : '0;
    assign out_pc         = out_valid ? pc_mem[head] : '0;
    assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - bench for fetch_prefetch_unit: directed literals plus randomized run against a queue model

module tb_fetch_prefetch_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst, redirect, load_stall, imem_valid, out_ready;
    logic [XLEN-1:0] redirect_pc, imem_rdata;
    logic            imem_req, imem_we_re, out_valid, fetch_misalign;
    logic [3:0]      imem_mask;
    logic [XLEN-1:0] imem_addr, out_instr, out_pc;

    always #5 clk = ~clk;

    fetch_prefetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .load_stall(load_stall), .imem_req(imem_req), .imem_we_re(imem_we_re),
        .imem_mask(imem_mask), .imem_addr(imem_addr), .imem_valid(imem_valid),
        .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .fetch_misalign(fetch_misalign)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] q_pc[$];
    logic [31:0] q_in[$];
    logic [31:0] m_pc;
    bit          m_infl, m_orph, m_mis;

    bit          mem_busy;
    int          mem_wait;
    logic [31:0] mem_addr;
    int          lat_sel;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_in.delete();
        m_pc     = 32'h0;
        m_infl   = 0;
        m_orph   = 0;
        m_mis    = 0;
        mem_busy = 0;
        mem_wait = 0;
    endtask

    task automatic begin_cycle();
        @(posedge clk);
        #1;
        imem_valid = !rst && mem_busy && (mem_wait == 0);
        imem_rdata = imem_valid ? mem_word(mem_addr) : $urandom();
    endtask

    task automatic end_cycle();
        bit          exp_req, issue, pop, got, was_busy;
        int          lat;
        #3;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_orph)      exp_req = 0;
        else if (m_infl) exp_req = 1;
        else             exp_req = !load_stall && (q_pc.size() < DEPTH) && !redirect && !m_mis;

        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", {31'b0, out_valid}, {31'b0, q_pc.size() > 0});
        if (q_pc.size() > 0) begin
            chk("out_pc", out_pc, q_pc[0]);
            chk("out_instr", out_instr, q_in[0]);
        end
        chk("imem_we_re", {31'b0, imem_we_re}, 32'h0);
        chk("imem_mask", {28'b0, imem_mask}, 32'hF);
        chk("fetch_misalign", {31'b0, fetch_misalign}, {31'b0, m_mis});

        issue = exp_req && !m_infl;
        pop   = (q_pc.size() > 0) && out_ready && !redirect;
        got   = imem_valid;
        if (redirect) begin
            m_orph = got ? 1'b0 : (m_orph || m_infl);
            m_infl = 0;
            q_pc.delete();
            q_in.delete();
`ifdef FETCH_ALIGN_CHECK_EN
            m_pc = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) m_mis = 1;
`else
            m_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
        end else begin
            if (pop) begin
                void'(q_pc.pop_front());
                void'(q_in.pop_front());
            end
            if (got && m_orph) begin
                m_orph = 0;
            end else if (got && m_infl) begin
                q_pc.push_back(m_pc);
                q_in.push_back(imem_rdata);
                m_pc   = m_pc + 32'd4;
                m_infl = 0;
            end
            if (issue) m_infl = 1;
        end

        was_busy = mem_busy;
        if (got)           mem_busy = 0;
        else if (mem_busy) mem_wait--;
        if (imem_req && !was_busy) begin
            lat      = (lat_sel == 0) ? int'($urandom_range(1, 3)) : lat_sel;
            mem_busy = 1;
            mem_addr = imem_addr;
            mem_wait = lat - 1;
        end
    endtask

    task automatic do_reset();
        begin_cycle();
        rst = 1;
        end_cycle();
        begin_cycle();
        end_cycle();
        begin_cycle();
        rst = 0;
        end_cycle();
    endtask

    logic [31:0] seq_exp [3];
    int  npop;
    bit  found, waiting;
    bit  slow_mode;

    initial begin
        rst = 1; redirect = 0; redirect_pc = '0; load_stall = 0;
        imem_valid = 0; imem_rdata = '0; out_ready = 0;
        lat_sel = 1;
        model_reset();
        seq_exp[0] = 32'h0; seq_exp[1] = 32'h4; seq_exp[2] = 32'h8;

        // First cycle out of reset: reset outputs and the first request to address 0
        do_reset();
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_misalign", {31'b0, fetch_misalign}, 32'h0);
        chk("first_req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);

        npop = 0;
        for (int i = 0; i < 14; i++) begin
            begin_cycle();
            out_ready = 1;
            end_cycle();
            if (out_valid && out_ready && npop < 3) begin
                chk("seq_pc", out_pc, seq_exp[npop]);
                chk("seq_instr", out_instr, mem_word(seq_exp[npop]));
                npop++;
            end
        end
        chk("seq_pops", npop, 3);

        // Fill the FIFO with decode stalled, then release exactly one entry
        do_reset();
        for (int i = 0; i < 16; i++) begin
            begin_cycle();
            out_ready = 0;
            end_cycle();
        end
        chk("full_req", {31'b0, imem_req}, 32'h0);
        chk("full_valid", {31'b0, out_valid}, 32'h1);
        chk("full_head_pc", out_pc, 32'h0);
        begin_cycle();
        out_ready = 1;
        end_cycle();
        chk("pop_cycle_req", {31'b0, imem_req}, 32'h0);
        lat_sel = 3;
        begin_cycle();
        out_ready = 0;
        end_cycle();
        chk("refill_req", {31'b0, imem_req}, 32'h1);
        chk("refill_addr", imem_addr, 32'h10);

        // Redirect while waiting on a slow response
        begin_cycle();
        redirect = 1; redirect_pc = 32'h100;
        end_cycle();
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            begin_cycle();
            redirect = 0;
            lat_sel = 2;
            end_cycle();
            found = imem_req;
        end
        chk("redir_found", {31'b0, found}, 32'h1);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_flushed", {31'b0, out_valid}, 32'h0);

        // Redirect in the same cycle as the response
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            begin_cycle();
            if (imem_valid) begin
                redirect = 1; redirect_pc = 32'h200; found = 1;
            end
            end_cycle();
        end
        chk("same_found", {31'b0, found}, 32'h1);
        lat_sel = 3;
        begin_cycle();
        redirect = 0;
        end_cycle();
        chk("same_out_valid", {31'b0, out_valid}, 32'h0);
        chk("same_req", {31'b0, imem_req}, 32'h1);
        chk("same_addr", imem_addr, 32'h200);

        // load_stall does not withdraw an issued request, but blocks new ones
        waiting = 1;
        for (int i = 0; i < 6; i++) begin
            begin_cycle();
            load_stall = 1;
            end_cycle();
            chk("stall_req", {31'b0, imem_req}, {31'b0, waiting});
            if (imem_valid) waiting = 0;
        end
        chk("stall_resp_seen", {31'b0, waiting}, 32'h0);
        lat_sel = 1;

        // Misaligned redirect
        begin_cycle();
        load_stall = 0; out_ready = 1;
        redirect = 1; redirect_pc = 32'h102;
        end_cycle();
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            begin_cycle();
            redirect = 0;
            end_cycle();
            found = imem_req;
        end
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misalign_flag", {31'b0, fetch_misalign}, 32'h1);
        chk("misalign_no_req", {31'b0, found}, 32'h0);
`else
        chk("align_found", {31'b0, found}, 32'h1);
        chk("align_addr", imem_addr, 32'h100);
        chk("align_flag", {31'b0, fetch_misalign}, 32'h0);
`endif

        // Randomized traffic
        lat_sel = 0;
        do_reset();
        slow_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            begin_cycle();
            if (i % 50 == 0) slow_mode = ($urandom_range(0, 2) == 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom() & 32'h0000_3FFC;
`ifndef FETCH_ALIGN_CHECK_EN
            if ($urandom_range(0, 3) == 0) redirect_pc = redirect_pc | 32'h2;
`endif
            load_stall = ($urandom_range(0, 4) == 0);
            out_ready  = slow_mode ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            end_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
